// File: rtl/dram_uart_dumper.sv
// Post-run DRAM dumper: after the processor finishes, streams a fixed DRAM window
// out as UART 8N1 frames while holding ownership of the DRAM address port.
module dram_uart_dumper #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [15:0] START_ADDR   = 16'h0000,
    parameter logic [15:0] LENGTH       = 16'd256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ram_out,
    output logic [15:0] dram_addr,
    output logic        dram_owner,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LAST_BYTE = LENGTH - 16'd1;
    localparam logic        EMPTY_RUN = (LENGTH == 16'd0);

    state_t      state_r;
    state_t      state_s;
    logic        start_d_r;
    logic [15:0] addr_r;
    logic [15:0] addr_s;
    logic [15:0] byte_cnt_r;
    logic [15:0] byte_cnt_s;
    logic [15:0] baud_r;
    logic [15:0] baud_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        tx_r;
    logic        tx_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        start_edge_s;
    logic        baud_end_s;

    assign start_edge_s = start & ~start_d_r;
    assign baud_end_s   = (baud_r == BAUD_LAST);

    // Line level is registered from the current state, so it lags the FSM by one cycle
    function automatic logic line_level(input state_t st, input logic [7:0] sh, input logic [2:0] idx);
        logic lvl;
        case (st)
            S_START: lvl = 1'b0;
            S_DATA:  lvl = sh[idx];
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_d_r  <= 1'b0;
            addr_r     <= START_ADDR;
            byte_cnt_r <= 16'd0;
            baud_r     <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            start_d_r  <= start;
            addr_r     <= addr_s;
            byte_cnt_r <= byte_cnt_s;
            baud_r     <= baud_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        byte_cnt_s = byte_cnt_r;
        baud_s     = baud_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        busy_s     = busy_r;
        done_s     = done_r;
        tx_s       = line_level(state_r, shift_r, bit_idx_r);

        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_edge_s) begin
                    if (EMPTY_RUN) begin
                        state_s = S_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s    = S_ADDR;
                        addr_s     = START_ADDR;
                        byte_cnt_s = 16'd0;
                        busy_s     = 1'b1;
                        done_s     = 1'b0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_ADDR: begin
                state_s = S_LOAD;
            end
            S_LOAD: begin
                shift_s = ram_out;
                baud_s  = 16'd0;
                state_s = S_START;
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_s    = 16'd0;
                    bit_idx_s = 3'd0;
                    state_s   = S_DATA;
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = S_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_s = S_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 16'd1;
                        addr_s     = addr_r + 16'd1;
                        state_s    = S_ADDR;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                tx_s    = 1'b1;
            end
        endcase
    end

    assign dram_addr  = addr_r;
    assign dram_owner = busy_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign tx         = tx_r;

endmodule
